// File: rtl/fp_sched_pkg.sv
// Shared constants and tag type for the fp add/sub scheduler.
package fp_sched_pkg;
    localparam logic ADD_SEL = 1'b1;
    localparam logic SUB_SEL = 1'b0;
    // Tag ids are sized for the largest supported requester count (8).
    localparam int TAG_IDW = 3;

    typedef struct packed {
        logic               valid;
        logic [TAG_IDW-1:0] id;
    } tag_t;
endpackage

// File: rtl/fp_addsub_sched_if.sv
// Requester-side request/response bundle for fp_addsub_sched.
interface fp_addsub_sched_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_op;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]         rsp_result;

    modport master (
        output req_valid, req_a, req_b, req_op,
        input  req_ready, rsp_valid, rsp_result
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op,
        output req_ready, rsp_valid, rsp_result
    );
endinterface

// File: rtl/fp_addsub_sched_rr_arbiter.sv
// Combinational round-robin pick: first set req above ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);
    always_comb begin : pick
        logic found;
        int   idx;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fp_addsub_sched.sv
// Round-robin scheduler sharing one pipelined fp add/sub unit among
// NUM_REQ requesters; a tag pipeline routes each result back to its issuer.
module fp_addsub_sched
    import fp_sched_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 1,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hold,
    fp_addsub_sched_if.slave   bus,
    output logic [WIDTH-1:0]   unit_a,
    output logic [WIDTH-1:0]   unit_b,
    output logic               unit_op,
    input  logic [WIDTH-1:0]   unit_result,
    output logic [3:0]         inflight
);
    logic [IDW-1:0]     ptr_q;
    logic [IDW-1:0]     gnt_id;
    logic [NUM_REQ-1:0] req_eff;
    logic [NUM_REQ-1:0] gnt;
    logic               hs;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic               sel_op;
    tag_t               tag_pipe [LATENCY];
    tag_t               tag_last;
    logic               rsp_fire;

    // hold only blocks new grants; the tag pipeline keeps draining.
    assign req_eff = hold ? '0 : bus.req_valid;

    rr_arbiter #(.N(NUM_REQ), .PW(IDW)) u_arb (
        .req (req_eff),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    assign bus.req_ready = gnt;
    assign hs            = |(gnt & bus.req_valid);

    always_comb begin
        gnt_id = '0;
        sel_a  = '0;
        sel_b  = '0;
        sel_op = ADD_SEL;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_id = IDW'(i);
                sel_a  = bus.req_a[i*WIDTH +: WIDTH];
                sel_b  = bus.req_b[i*WIDTH +: WIDTH];
                sel_op = bus.req_op[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= IDW'(NUM_REQ-1);
            unit_a  <= '0;
            unit_b  <= '0;
            unit_op <= ADD_SEL;
        end else if (hs) begin
            ptr_q   <= gnt_id;
            unit_a  <= sel_a;
            unit_b  <= sel_b;
            unit_op <= sel_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < LATENCY; s++) tag_pipe[s] <= '0;
        end else begin
            tag_pipe[0] <= hs ? {1'b1, TAG_IDW'(gnt_id)} : '0;
            for (int s = 1; s < LATENCY; s++) tag_pipe[s] <= tag_pipe[s-1];
        end
    end

    assign tag_last = tag_pipe[LATENCY-1];
    assign rsp_fire = tag_last.valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_valid  <= '0;
            bus.rsp_result <= '0;
            inflight       <= '0;
        end else begin
            bus.rsp_valid <= rsp_fire ? (NUM_REQ'(1) << tag_last.id) : '0;
            if (rsp_fire) bus.rsp_result <= unit_result;
            inflight <= inflight + 4'(hs) - 4'(rsp_fire);
        end
    end
endmodule
